// File: rtl/nsum_req_dispatcher.sv
// Circular FIFO with registered occupancy count; push and pop may coincide on the same edge.
// Latency: a pushed entry is visible at the head in the cycle after the push edge.
// Backpressure: the parent gates push with count<DEPTH; pop is only asserted when count!=0.
module nsum_req_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Queues N requests and issues them one at a time to NSUM, waiting for each result or a watchdog timeout.
// Latency: a request accepted into an empty, idle dispatcher is driven on N/N_valid in the cycle after the following edge.
// Backpressure: req_ready drops while the FIFO holds DEPTH entries; issue spacing is at least 3 cycles.
module nsum_req_dispatcher #(
    parameter int N_W     = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [N_W-1:0]           req_n,
    output logic                     req_ready,
    output logic [N_W-1:0]           N,
    output logic                     N_valid,
    input  logic                     sum_valid,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               done_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer;
    logic           sv_q;
    logic           sv_edge;
    logic           push, pop;
    logic [N_W-1:0] head_dat;

    // Ready comes from the registered count, so a same-edge pop never frees a slot early.
    assign req_ready = (fifo_count < CW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign sv_edge   = sum_valid && !sv_q;
    assign busy      = (state != S_IDLE) || (fifo_count != '0);

    nsum_req_fifo #(.W(N_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (req_n),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (sv_edge || (timer == TMAX)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            N           <= '0;
            N_valid     <= 1'b0;
            timer       <= '0;
            sv_q        <= 1'b0;
            timeout_err <= 1'b0;
            done_cnt    <= '0;
        end else begin
            sv_q    <= sum_valid;
            N_valid <= pop;
            // N is held after completion or timeout because NSUM may sample it late.
            if (pop) N <= head_dat;
            case (state)
                S_ISSUE: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (sv_edge)            done_cnt    <= done_cnt + 8'd1;
                    else if (timer == TMAX) timeout_err <= 1'b1;
                end
                default: timer <= timer;
            endcase
        end
    end
endmodule

// File: tb/tb_nsum_req_dispatcher.sv
// Scoreboard bench for nsum_req_dispatcher with a programmable-latency NSUM stub.
module tb_nsum_req_dispatcher;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_n = '0;
    logic       req_ready;
    logic [2:0] N;
    logic       N_valid;
    logic       sum_valid;
    logic       busy;
    logic       timeout_err;
    logic [2:0] fifo_count;
    logic [7:0] done_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int issue_cnt = 0;
    int exp_q[$];
    logic nv_prev = 1'b0;

    int   stub_delay = -1;
    int   stub_cnt = 0;
    int   stub_hold = 0;
    logic stub_sv = 1'b0;
    logic sv_force = 1'b0;

    assign sum_valid = stub_sv | sv_force;

    nsum_req_dispatcher #(.N_W(3), .DEPTH(4), .TIMEOUT(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_n       (req_n),
        .req_ready   (req_ready),
        .N           (N),
        .N_valid     (N_valid),
        .sum_valid   (sum_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_count  (fifo_count),
        .done_cnt    (done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue monitor: every strobe must be one cycle wide and match the queue head.
    always @(negedge clk) begin
        if (!reset && N_valid) begin
            issue_cnt++;
            check_val("nv_one_cycle", int'(nv_prev), 0);
            if (exp_q.size() == 0) check_val("unexpected_issue", int'(N), -1);
            else check_val("issue_order", int'(N), exp_q.pop_front());
        end
        nv_prev = N_valid && !reset;
    end

    // NSUM stub: raises sum_valid stub_delay cycles after seeing N_valid, holds it 2 cycles.
    always @(negedge clk) begin
        if (reset) begin
            stub_cnt  = 0;
            stub_hold = 0;
            stub_sv   = 1'b0;
        end else begin
            if (stub_hold > 0) begin
                stub_hold--;
                if (stub_hold == 0) stub_sv = 1'b0;
            end
            if (N_valid && stub_delay > 0) begin
                stub_cnt = stub_delay;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    stub_sv   = 1'b1;
                    stub_hold = 2;
                end
            end
        end
    end

    task automatic push_req(input int n);
        int w = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 3'(n);
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check_val("push_accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            accept_cyc = cyc;
            req_valid  = 1'b0;
            exp_q.push_back(n);
        end
    endtask

    task automatic wait_issue(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!N_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, int'(N_valid), 1);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(done_cnt) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, int'(done_cnt), target);
    endtask

    task automatic pulse_force();
        @(negedge clk);
        sv_force = 1'b1;
        repeat (2) @(negedge clk);
        sv_force = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        // Reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_N", int'(N), 0);
        check_val("rst_N_valid", int'(N_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_fifo_count", int'(fifo_count), 0);
        check_val("rst_timeout_err", int'(timeout_err), 0);
        check_val("rst_done_cnt", int'(done_cnt), 0);
        check_val("rst_req_ready", int'(req_ready), 1);

        // Single request, response 6 cycles after issue
        stub_delay = 6;
        push_req(5);
        wait_issue("single_issue", 10);
        check_val("single_latency", cyc - accept_cyc, 1);
        check_val("single_busy_issue", int'(busy), 1);
        repeat (5) @(negedge clk);
        check_val("single_busy_wait", int'(busy), 1);
        wait_done("single_done", 1, 20);
        check_val("single_busy_after", int'(busy), 0);

        // Response lands on the timer==TIMEOUT-1 cycle: completion wins
        stub_delay = 32;
        push_req(7);
        wait_done("edge_vs_timeout_done", 2, 60);
        check_val("edge_vs_timeout_err", int'(timeout_err), 0);
        repeat (3) @(negedge clk);

        // Backpressure with a silent NSUM
        stub_delay = -1;
        push_req(3);
        push_req(1);
        push_req(7);
        push_req(2);
        push_req(6);
        @(negedge clk);
        check_val("bp_fifo_full", int'(fifo_count), 4);
        check_val("bp_ready_low", int'(req_ready), 0);
        fork
            push_req(4);
        join_none
        repeat (3) @(negedge clk);
        check_val("bp_held_count", int'(fifo_count), 4);
        check_val("bp_held_queue", exp_q.size(), 4);
        stub_delay = 4;
        pulse_force();
        wait_done("bp_drain_done", 8, 150);
        check_val("bp_sb_empty", exp_q.size(), 0);
        check_val("bp_no_err", int'(timeout_err), 0);
        repeat (3) @(negedge clk);

        // Watchdog timeout, next queued request still issues
        stub_delay = -1;
        push_req(4);
        push_req(5);
        wait_issue("to_issue", 10);
        @(negedge clk);
        stub_delay = 3;
        repeat (31) @(negedge clk);
        check_val("to_err_before", int'(timeout_err), 0);
        @(negedge clk);
        check_val("to_err_set", int'(timeout_err), 1);
        check_val("to_done_unchanged", int'(done_cnt), 8);
        wait_done("to_next_done", 9, 20);
        check_val("to_err_sticky", int'(timeout_err), 1);
        repeat (3) @(negedge clk);

        // sum_valid held high through IDLE/ISSUE must not count as a completion
        stub_delay = -1;
        @(negedge clk);
        sv_force = 1'b1;
        push_req(6);
        wait_issue("hold_issue", 10);
        repeat (40) @(negedge clk);
        check_val("hold_no_done", int'(done_cnt), 9);
        check_val("hold_sb_empty", exp_q.size(), 0);
        sv_force = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while WAITing with a request still queued
        push_req(2);
        push_req(3);
        wait_issue("rstmid_issue", 10);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        reset = 1'b0;
        #1;
        check_val("rstmid_busy", int'(busy), 0);
        check_val("rstmid_fifo_count", int'(fifo_count), 0);
        check_val("rstmid_N", int'(N), 0);
        check_val("rstmid_err", int'(timeout_err), 0);
        base = issue_cnt;
        pulse_force();
        repeat (10) @(negedge clk);
        check_val("rstmid_stale_done", int'(done_cnt), 0);
        check_val("rstmid_stale_issue", issue_cnt - base, 0);
        check_val("rstmid_ready", int'(req_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
